// File: rtl/data_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller for the memory stage.
// Latency: load hit 0 cycles (combinational); load miss = mem latency + 1; store = mem latency + 1.
// Backpressure: StallM holds the pipeline on load misses and all stores until the backing memory acks.
module data_cache_ctrl #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int SET_BITS      = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     MemReadM,
    input  logic                     MemWriteM,
    input  logic                     a_typeM,
    input  logic [ADDRESS_WIDTH-1:0] ALUResultM,
    input  logic [DATA_WIDTH-1:0]    WriteDataM,
    output logic [DATA_WIDTH-1:0]    ReadDataM,
    output logic                     StallM,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic                     mem_byte,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    input  logic                     mem_ack
);

    localparam int NUM_SETS = 1 << SET_BITS;
    localparam int TAG_BITS = ADDRESS_WIDTH - SET_BITS - 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;

    logic [1:0]            state_q, state_d;
    logic                  done_q, done_d;
    logic [NUM_SETS-1:0]   valid_q, valid_d;
    logic [TAG_BITS-1:0]   tag_q  [NUM_SETS];
    logic [DATA_WIDTH-1:0] data_q [NUM_SETS];

    logic [1:0]            off;
    logic [SET_BITS-1:0]   idx;
    logic [TAG_BITS-1:0]   tag;
    logic                  line_match;
    logic [DATA_WIDTH-1:0] line_word;
    logic [7:0]            line_byte;
    logic                  is_store;
    logic                  is_load;
    logic                  load_hit;
    logic                  line_we;
    logic [DATA_WIDTH-1:0] line_wdata;

    assign off        = ALUResultM[1:0];
    assign idx        = ALUResultM[SET_BITS+1:2];
    assign tag        = ALUResultM[ADDRESS_WIDTH-1:SET_BITS+2];
    assign line_match = valid_q[idx] && (tag_q[idx] == tag);
    assign line_word  = data_q[idx];
    assign line_byte  = line_word[{off, 3'b000} +: 8];
    // A simultaneous read and write request is a store; the read half is dropped.
    assign is_store   = MemWriteM;
    assign is_load    = MemReadM && !MemWriteM;
    assign load_hit   = is_load && line_match;

    // Next-state, done flag, valid bits and line write-enable.
    always_comb begin
        state_d    = state_q;
        done_d     = done_q;
        valid_d    = valid_q;
        line_we    = 1'b0;
        line_wdata = line_word;
        case (state_q)
            ST_IDLE: begin
                // done only survives the single retire cycle of a finished store
                done_d = 1'b0;
                if (is_store) begin
                    if (!done_q) begin
                        state_d = ST_WRITE;
                    end
                end else if (is_load && !load_hit) begin
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if (mem_ack) begin
                    line_we      = 1'b1;
                    line_wdata   = mem_rdata;
                    valid_d[idx] = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (mem_ack) begin
                    // no allocate on a store miss; only refresh a resident copy
                    if (line_match) begin
                        line_we = 1'b1;
                        if (a_typeM) begin
                            line_wdata[{off, 3'b000} +: 8] = WriteDataM[7:0];
                        end else begin
                            line_wdata = WriteDataM;
                        end
                    end
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // a fill interrupted by reset must never leave data behind
        if (RST) begin
            line_we = 1'b0;
        end
    end

    // Control state with synchronous reset; tag/data arrays are never reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            valid_q <= valid_d;
        end
    end

    // Line storage: tag and data written together on fill or store hit.
    always_ff @(posedge CLK) begin
        if (line_we) begin
            tag_q[idx]  <= tag;
            data_q[idx] <= line_wdata;
        end
    end

    // Pipeline stall, load data and backing-memory request outputs.
    always_comb begin
        StallM    = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_byte  = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        ReadDataM = '0;
        case (state_q)
            ST_IDLE: begin
                if (is_store) begin
                    StallM = !done_q;
                end else if (is_load) begin
                    StallM = !load_hit;
                    if (load_hit) begin
                        ReadDataM = a_typeM ? {{(DATA_WIDTH-8){1'b0}}, line_byte} : line_word;
                    end
                end
            end
            ST_FILL: begin
                StallM   = 1'b1;
                mem_req  = 1'b1;
                mem_addr = {ALUResultM[ADDRESS_WIDTH-1:2], 2'b00};
            end
            ST_WRITE: begin
                StallM    = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_byte  = a_typeM;
                mem_addr  = ALUResultM;
                mem_wdata = WriteDataM;
            end
            default: begin
                StallM = 1'b0;
            end
        endcase
        // the request drops in the very cycle reset is asserted
        if (RST) begin
            StallM   = 1'b0;
            mem_req  = 1'b0;
            mem_we   = 1'b0;
            mem_byte = 1'b0;
        end
    end

endmodule
